// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker for a Viterbi decoder loop: buffers source bits, aligns
// them with decoded bits, and tracks total and per-window error counts plus lock state.
module viterbi_ber_checker #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned SKIP  = 16,
   parameter int unsigned WIN   = 256,
   parameter int unsigned THR   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        src_valid,
   input  logic        src_bit,
   input  logic        dec_valid,
   input  logic        dec_bit,
   output logic        err_o,
   output logic [31:0] bit_ct,
   output logic [31:0] err_ct,
   output logic [15:0] win_err,
   output logic        win_done,
   output logic        locked,
   output logic        overflow,
   output logic        underflow
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
   localparam int unsigned WW = (WIN > 1) ? $clog2(WIN) : 1;

   typedef enum logic [1:0] {IDLE, FLUSH, COUNT, FAIL} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   skip_q, skip_d;

   logic            mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   cnt_q;

   logic [WW-1:0]   win_cnt_q;
   logic [15:0]     win_acc_q;

   logic            fifo_full, fifo_empty;
   logic            do_push, do_pop;
   logic            pop_bit, mis, cmp, win_end;
   logic [16:0]     win_sum;

   // FIFO handshake and compare qualification; clear masks all traffic
   always_comb begin
      fifo_full  = (cnt_q == CW'(DEPTH));
      fifo_empty = (cnt_q == '0);
      do_pop     = dec_valid && !fifo_empty && !clear;
      do_push    = src_valid && !clear && (!fifo_full || do_pop);
      pop_bit    = mem[rd_ptr_q];
      mis        = pop_bit ^ dec_bit;
      cmp        = do_pop && ((state_q == COUNT) || (state_q == FAIL));
      win_end    = cmp && (win_cnt_q == WW'(WIN - 1));
      win_sum    = {1'b0, win_acc_q} + 17'(mis);
   end

   // Lock FSM next state; window verdict uses the sum including the closing bit
   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      case (state_q)
         IDLE: begin
            if (do_pop) begin
               if (SKIP <= 1) begin
                  state_d = COUNT;
               end else begin
                  state_d = FLUSH;
                  skip_d  = SW'(1);
               end
            end
         end
         FLUSH: begin
            if (do_pop) begin
               if (skip_q == SW'(SKIP - 1)) begin
                  state_d = COUNT;
               end
               skip_d = skip_q + SW'(1);
            end
         end
         COUNT: begin
            if (win_end && (32'(win_sum) > THR)) begin
               state_d = FAIL;
            end
         end
         FAIL: begin
            if (win_end && (win_sum == '0)) begin
               state_d = COUNT;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clear) begin
         state_d = IDLE;
         skip_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         skip_q  <= '0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
      end
   end

   // Source-bit storage; contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= src_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Registered compare results, window accumulation and sticky flags
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         err_o     <= 1'b0;
         bit_ct    <= '0;
         err_ct    <= '0;
         win_err   <= '0;
         win_done  <= 1'b0;
         locked    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         win_cnt_q <= '0;
         win_acc_q <= '0;
      end else begin
         err_o    <= cmp && mis;
         win_done <= win_end;
         locked   <= (state_d == COUNT);
         if (cmp) begin
            if (bit_ct != '1) bit_ct <= bit_ct + 32'd1;
            if (mis && (err_ct != '1)) err_ct <= err_ct + 32'd1;
            if (win_end) begin
               win_err   <= win_sum[16] ? 16'hFFFF : win_sum[15:0];
               win_cnt_q <= '0;
               win_acc_q <= '0;
            end else begin
               win_cnt_q <= win_cnt_q + WW'(1);
               if (mis && (win_acc_q != '1)) win_acc_q <= win_acc_q + 16'd1;
            end
         end
         if (src_valid && fifo_full && !do_pop) overflow <= 1'b1;
         if (dec_valid && fifo_empty) underflow <= 1'b1;
      end
   end

endmodule

// File: doc/viterbi_ber_checker.md
VITERBI_BER_CHECKER -- requirements
Module: viterbi_ber_checker

Interface
REQ-001 Parameter DEPTH, default 64: source-bit FIFO depth, power of two, maximum tolerated encoder-to-decoder latency in bits.
REQ-002 Parameter SKIP, default 16: decoded bits discarded after start, covering traceback flush.
REQ-003 Parameter WIN, default 256: compared bits per measurement window.
REQ-004 Parameter THR, default 8: maximum window errors still considered locked.
REQ-005 clk  in  1  sole clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 clear  in  1  synchronous restart of counters, FIFO and FSM.
REQ-008 src_valid  in  1  source bit presented to encoder this cycle.
REQ-009 src_bit  in  1  source bit value.
REQ-010 dec_valid  in  1  decoded bit valid this cycle.
REQ-011 dec_bit  in  1  decoded bit value.
REQ-012 err_o  out  1  one-cycle pulse: last compared bit mismatched.
REQ-013 bit_ct  out  32  compared bits since start (excluding SKIP).
REQ-014 err_ct  out  32  mismatched bits since start.
REQ-015 win_err  out  16  error count of last completed window.
REQ-016 win_done  out  1  one-cycle pulse: window completed, win_err updated.
REQ-017 locked  out  1  high in COUNT state.
REQ-018 overflow  out  1  sticky: src_valid while FIFO full and no pop.
REQ-019 underflow  out  1  sticky: dec_valid while FIFO empty.

Function
REQ-020 The block SHALL push src_bit into the FIFO on src_valid and pop one entry on each dec_valid, comparing the popped bit with dec_bit.
REQ-021 Push and pop in the same cycle SHALL both occur, including at full (count unchanged) and at empty (push only; pop counts as underflow).
REQ-022 Push at full without pop SHALL be dropped and set overflow; dec_valid at empty SHALL perform no compare and set underflow.
REQ-023 FSM states SHALL be IDLE, FLUSH, COUNT, FAIL; reset and clear enter IDLE.
REQ-024 IDLE->FLUSH on first dec_valid with non-empty FIFO; that pop is the first discarded bit.
REQ-025 FLUSH SHALL discard SKIP pops without compare, then go to COUNT on the cycle after the SKIP-th pop.
REQ-026 In COUNT and FAIL every pop SHALL be compared; bit_ct increments by 1, err_ct and the window accumulator increment on mismatch.
REQ-027 Compare results SHALL be registered: err_o, bit_ct, err_ct reflect a pop one cycle after the dec_valid cycle.
REQ-028 After WIN compares, win_err SHALL load the accumulator (including the WIN-th bit), win_done pulses, accumulator restarts at 0 in the same cycle.
REQ-029 At window end, COUNT->FAIL if window errors > THR; FAIL->COUNT if window errors == 0; otherwise state holds.
REQ-030 bit_ct and err_ct SHALL saturate at 32'hFFFF_FFFF; win_err saturates at 16'hFFFF.
REQ-031 clear SHALL take priority over simultaneous src_valid/dec_valid; those inputs are ignored that cycle.
REQ-032 overflow and underflow SHALL remain set until rst or clear.

Reset
REQ-033 On rst (and clear), SHALL set: FIFO empty, state IDLE, err_o=0, bit_ct=0, err_ct=0, win_err=0, win_done=0, locked=0, overflow=0, underflow=0.
REQ-034 rst asserted mid-window SHALL discard the partial window with no win_done pulse.

Verification
REQ-035 Error-free loop, latency 20 bits, 300 src bits -> locked after 16 skipped pops; bit_ct=284, err_ct=0, one win_done with win_err=0.
REQ-036 Invert dec_bit on compares 5 and 9 of first window -> err_o pulses at those compares, err_ct=2, win_err=2, locked stays 1.
REQ-037 Invert 10 of 256 bits in a window -> win_err=10, locked falls after win_done; next clean window -> locked returns to 1.
REQ-038 65 src_valid with no dec_valid (DEPTH=64) -> overflow=1 on 65th push, FIFO holds 64; then simultaneous push/pop at full -> no further overflow.
REQ-039 dec_valid with empty FIFO after reset -> underflow=1, state IDLE, bit_ct=0.
REQ-040 clear asserted with src_valid and dec_valid high mid-window -> all counters 0, state IDLE, FIFO empty, no win_done.
